// File: rtl/snd_cif_pkg.sv
// Shared definitions for the sound-register CIF master: bus widths,
// controller state encoding and the sound slave register map.
package snd_cif_pkg;

    localparam int SND_CIF_AW = 4;
    localparam int SND_CIF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_RESP  = 2'd3
    } snd_cif_state_e;

    // Sound slave register map
    localparam logic [SND_CIF_AW-1:0] ADR_CMD      = 4'd0;
    localparam logic [SND_CIF_AW-1:0] ADR_VRAMADR  = 4'd1;
    localparam logic [SND_CIF_AW-1:0] ADR_VOLUME   = 4'd2;
    localparam logic [SND_CIF_AW-1:0] ADR_LOOP     = 4'd3;
    localparam logic [SND_CIF_AW-1:0] ADR_DEM_MUTE = 4'd4;
    localparam logic [SND_CIF_AW-1:0] ADR_STATUS   = 4'd5;
    localparam logic [SND_CIF_AW-1:0] ADR_MUSIC    = 4'd6;
    localparam logic [SND_CIF_AW-1:0] ADR_DELAY    = 4'd7;

    // Reload value for the read-wait counter: the counter is loaded on the
    // edge that ends ISSUE and the data is sampled when it has reached zero.
    function automatic logic [3:0] lat_load(input int rd_latency);
        return 4'(rd_latency - 1);
    endfunction

endpackage

// File: rtl/snd_cifmaster.sv
// CIF master for the sound register slave. Accepts one register command at a
// time on the REQ_* side, runs a single strobed bus cycle on CIF_*, and returns
// the result on RSP_*.
//
// Handshake: a transfer happens on a rising edge where VALID && READY are both
// high; the sender keeps its payload stable while VALID is high and READY low,
// and the receiver may not assume anything about payload while VALID is low.
module snd_cifmaster
    import snd_cif_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int DW         = SND_CIF_DW,
    parameter int AW         = SND_CIF_AW
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WRITE,
    input  logic [AW-1:0] REQ_ADR,
    input  logic [3:0]    REQ_BE,
    input  logic [DW-1:0] REQ_WDATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic          RSP_WRITE,
    output logic [DW-1:0] RSP_RDATA,
    output logic          CIF_SNDSEL,
    output logic          CIF_REGREAD,
    output logic [3:0]    CIF_REGWRITE,
    output logic [AW-1:0] CIF_REGADR,
    output logic [DW-1:0] CIF_REGWDATA,
    input  logic [DW-1:0] SND_REGRDATA,
    output logic          BUSY,
    output logic [1:0]    DBG_STATE
);

    localparam logic [3:0] LAT_LOAD = lat_load(RD_LATENCY);

    snd_cif_state_e state;
    logic           cap_write;
    logic [3:0]     lat_cnt;

    // Ready is gated by RST_X so it is low throughout reset and high on the
    // very first cycle after release.
    assign REQ_READY = (state == ST_IDLE) && RST_X;
    assign BUSY      = (state != ST_IDLE);
    assign DBG_STATE = state;

    // Command sequencer: all bus strobes and response fields are registered here
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state        <= ST_IDLE;
            cap_write    <= 1'b0;
            lat_cnt      <= '0;
            CIF_SNDSEL   <= 1'b0;
            CIF_REGREAD  <= 1'b0;
            CIF_REGWRITE <= '0;
            CIF_REGADR   <= '0;
            CIF_REGWDATA <= '0;
            RSP_VALID    <= 1'b0;
            RSP_WRITE    <= 1'b0;
            RSP_RDATA    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        cap_write    <= REQ_WRITE;
                        CIF_REGADR   <= REQ_ADR;
                        CIF_REGWDATA <= REQ_WDATA;
                        if (REQ_WRITE) begin
                            // A write with no byte enables never selects the slave
                            CIF_SNDSEL   <= |REQ_BE;
                            CIF_REGREAD  <= 1'b0;
                            CIF_REGWRITE <= REQ_BE;
                        end else begin
                            CIF_SNDSEL   <= 1'b1;
                            CIF_REGREAD  <= 1'b1;
                            CIF_REGWRITE <= '0;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    CIF_SNDSEL   <= 1'b0;
                    CIF_REGREAD  <= 1'b0;
                    CIF_REGWRITE <= '0;
                    if (cap_write) begin
                        RSP_VALID <= 1'b1;
                        RSP_WRITE <= 1'b1;
                        RSP_RDATA <= '0;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (lat_cnt == 4'd0) begin
                        RSP_VALID <= 1'b1;
                        RSP_WRITE <= 1'b0;
                        RSP_RDATA <= SND_REGRDATA;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snd_cifmaster.sv
// Bench for snd_cifmaster: two instances (read latency 1 and 3), each paired
// with a sound register slave model, and a register-file reference model.
module tb_snd_cifmaster;
    import snd_cif_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_x;
    logic        slv_clr;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_adr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_write, a_sndsel, a_regread, a_busy;
    logic [3:0]  a_regwrite, a_regadr;
    logic [31:0] a_rsp_rdata, a_regwdata, a_rdata;
    logic [1:0]  a_state;
    logic        b_req_ready, b_rsp_valid, b_rsp_write, b_sndsel, b_regread, b_busy;
    logic [3:0]  b_regwrite, b_regadr;
    logic [31:0] b_rsp_rdata, b_regwdata, b_rdata;
    logic [1:0]  b_state;

    snd_cifmaster #(.RD_LATENCY(1), .DW(32), .AW(4)) u_dut_a (
        .CLK(clk), .RST_X(rst_x),
        .REQ_VALID(req_valid && !sel), .REQ_READY(a_req_ready), .REQ_WRITE(req_write),
        .REQ_ADR(req_adr), .REQ_BE(req_be), .REQ_WDATA(req_wdata),
        .RSP_VALID(a_rsp_valid), .RSP_READY(rsp_ready && !sel), .RSP_WRITE(a_rsp_write),
        .RSP_RDATA(a_rsp_rdata), .CIF_SNDSEL(a_sndsel), .CIF_REGREAD(a_regread),
        .CIF_REGWRITE(a_regwrite), .CIF_REGADR(a_regadr), .CIF_REGWDATA(a_regwdata),
        .SND_REGRDATA(a_rdata), .BUSY(a_busy), .DBG_STATE(a_state)
    );

    snd_cifmaster #(.RD_LATENCY(3), .DW(32), .AW(4)) u_dut_b (
        .CLK(clk), .RST_X(rst_x),
        .REQ_VALID(req_valid && sel), .REQ_READY(b_req_ready), .REQ_WRITE(req_write),
        .REQ_ADR(req_adr), .REQ_BE(req_be), .REQ_WDATA(req_wdata),
        .RSP_VALID(b_rsp_valid), .RSP_READY(rsp_ready && sel), .RSP_WRITE(b_rsp_write),
        .RSP_RDATA(b_rsp_rdata), .CIF_SNDSEL(b_sndsel), .CIF_REGREAD(b_regread),
        .CIF_REGWRITE(b_regwrite), .CIF_REGADR(b_regadr), .CIF_REGWDATA(b_regwdata),
        .SND_REGRDATA(b_rdata), .BUSY(b_busy), .DBG_STATE(b_state)
    );

    // ---------------- sound slave models ----------------
    logic [31:0] a_regs [16];
    logic [31:0] a_pipe;
    logic [31:0] b_regs [16];
    logic [31:0] b_pipe [3];

    // Latency-1 slave: byte writes on strobe, read data registered once
    always_ff @(posedge clk) begin
        if (slv_clr) begin
            for (int i = 0; i < 16; i++) a_regs[i] <= '0;
            a_pipe <= '0;
        end else begin
            if (a_sndsel)
                for (int k = 0; k < 4; k++)
                    if (a_regwrite[k]) a_regs[a_regadr][8*k +: 8] <= a_regwdata[8*k +: 8];
            a_pipe <= (a_sndsel && a_regread) ? a_regs[a_regadr] : '0;
        end
    end
    assign a_rdata = a_pipe;

    // Latency-3 slave: same register file, read data delayed three stages
    always_ff @(posedge clk) begin
        if (slv_clr) begin
            for (int i = 0; i < 16; i++) b_regs[i] <= '0;
            for (int i = 0; i < 3; i++) b_pipe[i] <= '0;
        end else begin
            if (b_sndsel)
                for (int k = 0; k < 4; k++)
                    if (b_regwrite[k]) b_regs[b_regadr][8*k +: 8] <= b_regwdata[8*k +: 8];
            b_pipe[0] <= (b_sndsel && b_regread) ? b_regs[b_regadr] : '0;
            b_pipe[1] <= b_pipe[0];
            b_pipe[2] <= b_pipe[1];
        end
    end
    assign b_rdata = b_pipe[2];

    // Outputs of the currently selected instance
    logic        m_req_ready, m_rsp_valid, m_rsp_write, m_sndsel, m_regread, m_busy;
    logic [3:0]  m_regwrite, m_regadr;
    logic [31:0] m_rsp_rdata, m_regwdata;
    logic [1:0]  m_state;
    always_comb begin
        m_req_ready = sel ? b_req_ready : a_req_ready;
        m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
        m_rsp_write = sel ? b_rsp_write : a_rsp_write;
        m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
        m_sndsel    = sel ? b_sndsel    : a_sndsel;
        m_regread   = sel ? b_regread   : a_regread;
        m_regwrite  = sel ? b_regwrite  : a_regwrite;
        m_regadr    = sel ? b_regadr    : a_regadr;
        m_regwdata  = sel ? b_regwdata  : a_regwdata;
        m_busy      = sel ? b_busy      : a_busy;
        m_state     = sel ? b_state     : a_state;
    end

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] model_regs [2][16];
    logic [31:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // One full command on instance d: accept, bus cycle, response held for
    // 'hold' cycles, then handshake. Returns the observed read data.
    task automatic run_cmd(input int d, input logic wr, input logic [3:0] adr,
                           input logic [3:0] be, input logic [31:0] wd, input int hold,
                           output logic [31:0] got);
        int n;
        int edges;
        int lat;
        logic [31:0] exp_rd;
        logic strobe_bad;
        logic stable_bad;
        got = '0;
        sel = (d != 0);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = wr; req_adr = adr; req_be = be; req_wdata = wd;
        #1;
        n = 0;
        while (!m_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("accept", m_req_ready, 1'b1);
        if (!m_req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Payload changes after acceptance must not reach the active command
        req_valid = 1'b0; req_write = ~wr;
        req_adr = 4'($urandom); req_be = 4'($urandom); req_wdata = $urandom;
        @(negedge clk);
        edges = 1;
        check1("issue_sndsel", m_sndsel, wr ? (be != 4'd0) : 1'b1);
        check1("issue_regread", m_regread, !wr);
        check("issue_regwrite", 32'(m_regwrite), wr ? 32'(be) : 32'd0);
        check("issue_regadr", 32'(m_regadr), 32'(adr));
        check("issue_regwdata", m_regwdata, wd);
        check1("issue_busy", m_busy, 1'b1);
        check1("issue_rsp_valid", m_rsp_valid, 1'b0);
        if (wr) model_regs[d][adr] = merge(model_regs[d][adr], wd, be);
        exp_q.push_back(wr ? 32'd0 : model_regs[d][adr]);
        lat = wr ? 2 : 2 + ((d != 0) ? 3 : 1);
        strobe_bad = 1'b0;
        while (!m_rsp_valid && edges < lat + 4) begin
            @(negedge clk);
            edges++;
            if (m_sndsel || m_regread || m_regwrite != 4'd0) strobe_bad = 1'b1;
            if (m_regadr !== adr || m_regwdata !== wd) strobe_bad = 1'b1;
        end
        check("rsp_latency", 32'(edges), 32'(lat));
        check1("rsp_valid", m_rsp_valid, 1'b1);
        exp_rd = exp_q.pop_front();
        check1("rsp_write", m_rsp_write, wr);
        check("rsp_rdata", m_rsp_rdata, exp_rd);
        got = m_rsp_rdata;
        stable_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            // Requests offered while busy must be ignored
            req_valid = 1'($urandom_range(0, 1));
            req_adr = 4'($urandom); req_write = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!m_rsp_valid || m_rsp_rdata !== got || m_rsp_write !== wr || m_req_ready)
                stable_bad = 1'b1;
            if (m_sndsel || m_regread || m_regwrite != 4'd0) strobe_bad = 1'b1;
        end
        req_valid = 1'b0;
        check1("hold_stable", stable_bad, 1'b0);
        check1("strobes_idle", strobe_bad, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check1("after_rsp_valid", m_rsp_valid, 1'b0);
        check1("after_req_ready", m_req_ready, 1'b1);
        check1("after_busy", m_busy, 1'b0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        wr;
        logic [3:0]  adr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    // Watchdog keeps the run bounded even if a wait loop misbehaves
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        flag;

        vecs[0] = '{1'b1, ADR_VOLUME, 4'b0001, 32'h0000_00A5, 0, 32'h0};
        vecs[1] = '{1'b0, ADR_VOLUME, 4'b0000, 32'h0,         1, 32'h0000_00A5};
        vecs[2] = '{1'b1, ADR_MUSIC,  4'b1010, 32'h1122_3344, 0, 32'h0};
        vecs[3] = '{1'b0, ADR_MUSIC,  4'b0000, 32'h0,         0, 32'h1100_3300};
        vecs[4] = '{1'b1, ADR_DELAY,  4'b0000, 32'hDEAD_BEEF, 2, 32'h0};
        vecs[5] = '{1'b0, ADR_DELAY,  4'b0000, 32'h0,         0, 32'h0};
        vecs[6] = '{1'b1, ADR_STATUS, 4'b1111, 32'h5A5A_0001, 0, 32'h0};
        vecs[7] = '{1'b0, ADR_STATUS, 4'b0000, 32'h0,         5, 32'h5A5A_0001};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) model_regs[d][i] = '0;

        rst_x = 1'b0; slv_clr = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_adr = '0; req_be = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check1("rst_req_ready", m_req_ready, 1'b0);
        check1("rst_rsp_valid", m_rsp_valid, 1'b0);
        check1("rst_rsp_write", m_rsp_write, 1'b0);
        check("rst_rsp_rdata", m_rsp_rdata, 32'h0);
        check1("rst_sndsel", m_sndsel, 1'b0);
        check1("rst_regread", m_regread, 1'b0);
        check("rst_regwrite", 32'(m_regwrite), 32'h0);
        check("rst_regadr", 32'(m_regadr), 32'h0);
        check("rst_regwdata", m_regwdata, 32'h0);
        check1("rst_busy", m_busy, 1'b0);
        check("rst_state", 32'(m_state), 32'(ST_IDLE));
        rst_x = 1'b1; slv_clr = 1'b0;
        #1 check1("release_req_ready", m_req_ready, 1'b1);

        // Directed table on the latency-1 instance
        for (int i = 0; i < 8; i++) begin
            run_cmd(0, vecs[i].wr, vecs[i].adr, vecs[i].be, vecs[i].wd, vecs[i].hold, got);
            check("vec_rdata", got, vecs[i].exp);
        end

        // Randomized traffic against the register-file model
        repeat (40)
            run_cmd(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3), got);

        // Latency-3 instance
        run_cmd(1, 1'b1, ADR_VRAMADR, 4'b1111, 32'h007F_FFFF, 0, got);
        run_cmd(1, 1'b0, ADR_VRAMADR, 4'b0000, 32'h0, 2, got);
        check("lat3_rdata", got, 32'h007F_FFFF);
        repeat (10)
            run_cmd(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2), got);

        // Reset while a read is waiting for slave data
        sel = 1'b0; #1;
        req_valid = 1'b1; req_write = 1'b0; req_adr = ADR_STATUS; req_be = '0; req_wdata = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rwait_state", 32'(m_state), 32'(ST_RWAIT));
        rst_x = 1'b0;
        @(negedge clk);
        check1("abort_rsp_valid", m_rsp_valid, 1'b0);
        check1("abort_sndsel", m_sndsel, 1'b0);
        check1("abort_regread", m_regread, 1'b0);
        check("abort_regwrite", 32'(m_regwrite), 32'h0);
        check1("abort_busy", m_busy, 1'b0);
        check1("abort_req_ready", m_req_ready, 1'b0);
        rst_x = 1'b1;
        #1 check1("abort_release_ready", m_req_ready, 1'b1);
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (m_rsp_valid || m_sndsel || m_regread || m_busy) flag = 1'b1;
        end
        check1("abort_quiet", flag, 1'b0);
        run_cmd(0, 1'b0, ADR_STATUS, 4'b0000, 32'h0, 1, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snd_cifmaster.md
SND_CIFMASTER -- requirements
Module: snd_cifmaster

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from the read strobe cycle to the SND_REGRDATA sample edge (legal 1..15).
REQ-002 SHALL have parameter DW, default 32, meaning CIF data width.
REQ-003 SHALL have parameter AW, default 4, meaning CIF register address width.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 RST_X  input  1  reset, synchronous, active-low.
REQ-006 REQ_VALID  input  1  command request valid.
REQ-007 REQ_READY  output  1  command accepted when REQ_VALID && REQ_READY.
REQ-008 REQ_WRITE  input  1  1=register write, 0=register read.
REQ-009 REQ_ADR  input  AW  target register address.
REQ-010 REQ_BE  input  4  byte enables for writes; ignored for reads.
REQ-011 REQ_WDATA  input  DW  write data.
REQ-012 RSP_VALID  output  1  response valid.
REQ-013 RSP_READY  input  1  response consumed when RSP_VALID && RSP_READY.
REQ-014 RSP_WRITE  output  1  echo of REQ_WRITE of the completed command.
REQ-015 RSP_RDATA  output  DW  read data; 0 for write responses.
REQ-016 CIF_SNDSEL  output  1  sound slave select strobe.
REQ-017 CIF_REGREAD  output  1  read strobe.
REQ-018 CIF_REGWRITE  output  4  per-byte write strobes.
REQ-019 CIF_REGADR  output  AW  register address.
REQ-020 CIF_REGWDATA  output  DW  write data.
REQ-021 SND_REGRDATA  input  DW  registered read data returned by the slave.
REQ-022 BUSY  output  1  high in every state except IDLE.

Function
REQ-023 States SHALL be IDLE, ISSUE, RWAIT, RESP; all CIF_* and RSP_* outputs driven from flops.
REQ-024 REQ_READY SHALL be 1 only in IDLE; acceptance captures REQ_WRITE/ADR/BE/WDATA and moves to ISSUE.
REQ-025 In ISSUE (exactly one cycle) CIF_SNDSEL=1, CIF_REGADR/CIF_REGWDATA=captured values; write: CIF_REGWRITE=captured BE, CIF_REGREAD=0; read: CIF_REGREAD=1, CIF_REGWRITE=0.
REQ-026 Write with captured BE=0 SHALL skip the bus cycle (CIF_SNDSEL stays 0) and go directly to RESP.
REQ-027 After a write ISSUE, next state SHALL be RESP with RSP_RDATA=0, RSP_WRITE=1.
REQ-028 After a read ISSUE, RWAIT SHALL count down so SND_REGRDATA is sampled exactly RD_LATENCY edges after the ISSUE edge, then enter RESP with RSP_WRITE=0.
REQ-029 In RESP, RSP_VALID=1 and RSP_RDATA/RSP_WRITE SHALL stay stable until RSP_READY=1; then return to IDLE next cycle.
REQ-030 Outside ISSUE, CIF_SNDSEL, CIF_REGREAD, CIF_REGWRITE SHALL be 0; CIF_REGADR and CIF_REGWDATA hold last value.
REQ-031 Minimum command-to-response latency: write 2 cycles, read 1+RD_LATENCY+1 cycles from acceptance edge to RSP_VALID.
REQ-032 REQ_VALID deasserting while not accepted SHALL have no effect; REQ_* changes after acceptance SHALL not affect the active command.

Reset
REQ-033 On RST_X=0 at a rising edge: state=IDLE, REQ_READY=0 during reset, RSP_VALID=0, RSP_WRITE=0, RSP_RDATA=0, all CIF_* outputs=0, BUSY=0, latency counter=0.
REQ-034 Reset mid-command SHALL abort it: no strobe after the reset edge, pending response discarded; REQ_READY=1 on the first cycle after RST_X returns high.

Structure
REQ-035 Shared package snd_cif_pkg SHALL hold AW/DW defaults, state encoding, and register address constants (CMD=0, VRAMADR=1, VOLUME=2, LOOP=3, DEM/MUTE=4, STATUS=5, MUSIC=6, DELAY=7).
REQ-036 Single flat module; no sub-module.

Verification (bench pairs DUT with a model of the sound register slave, RD_LATENCY=1)
REQ-037 Write ADR=2, BE=4'b0001, WDATA=0x000000A5 -> one-cycle SNDSEL+REGWRITE=0001; next read of ADR=2 returns RSP_RDATA=0x000000A5.
REQ-038 Write ADR=6, BE=4'b1010, WDATA=0x11223344 over 0 -> read ADR=6 returns 0x11003300.
REQ-039 Write ADR=7, BE=0 -> no SNDSEL pulse, RSP_VALID 2 cycles after acceptance, RSP_WRITE=1, RSP_RDATA=0.
REQ-040 Read ADR=5 with RSP_READY held low 5 cycles -> RSP_VALID and RSP_RDATA stable throughout; REQ_READY=0 until 1 cycle after the handshake.
REQ-041 Assert RST_X=0 during RWAIT -> no RSP_VALID, all strobes 0, REQ_READY=1 first cycle after release.
REQ-042 Rebuild with RD_LATENCY=3, slave data delayed 3 cycles -> read of ADR=1 returns written 0x007FFFFF.
